motor_pwm_driver: RTL

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver_pkg.sv | 28 ++
 rtl/motor_pwm_driver_channel.sv | 133 +++++++++++++
 rtl/motor_pwm_driver.sv | 72 +++++++
 3 files changed

// File: rtl/motor_pwm_driver_pkg.sv
// Drive command encoding and channel types shared by
// the movement stage and the H-bridge PWM driver.
package motor_pwm_driver_pkg;

  localparam logic [1:0] DRV_STOP  = 2'b00;
  localparam logic [1:0] DRV_FWD   = 2'b01;
  localparam logic [1:0] DRV_REV   = 2'b10;
  localparam logic [1:0] DRV_BRAKE = 2'b11;

  localparam logic [1:0] PINS_OFF = 2'b00;
  localparam logic [1:0] PINS_FWD = 2'b10;
  localparam logic [1:0] PINS_REV = 2'b01;
  localparam logic [1:0] PINS_BRK = 2'b11;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_FWD,
    ST_REV,
    ST_BRAKE,
    ST_DEAD
  } chan_state_t;

  typedef struct packed {
    logic       en;
    logic [1:0] inx;
  } bridge_t;

endpackage

// File: rtl/motor_pwm_driver_channel.sv
// One H-bridge channel: direction FSM, duty ramp,
// reversal dead time and registered bridge pins.
module motor_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int PERIOD    = 20,
  parameter int DUTY_MIN  = 5,
  parameter int DUTY_MAX  = 20,
  parameter int RAMP_STEP = 5,
  parameter int DEADTIME  = 10,
  localparam int CW = $clog2(PERIOD + 1),
  localparam int DW = $clog2(DEADTIME + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cmd,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] cnt_nxt,
  output bridge_t       pins
);

  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] MIN_D = CW'(DUTY_MIN);
  localparam logic [CW-1:0] MAX_D = CW'(DUTY_MAX);
  localparam logic [CW:0]   STEP_W = (CW + 1)'(RAMP_STEP);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEADTIME - 1);

  chan_state_t   state_q, state_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [CW:0]   ramp;
  bridge_t       pins_d;

  assign ramp = {1'b0, duty_q} + STEP_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      duty_q  <= '0;
      dead_q  <= '0;
      pins    <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      pins    <= pins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    unique case (state_q)
      ST_FWD, ST_REV: begin
        if (cmd == DRV_STOP) begin
          state_d = ST_STOP;
          duty_d  = '0;
        end else if (cmd == DRV_BRAKE) begin
          state_d = ST_BRAKE;
          duty_d  = '0;
        end else if ((state_q == ST_FWD) == (cmd == DRV_REV)) begin
          state_d = ST_DEAD;
          duty_d  = '0;
          dead_d  = DEAD_INIT;
        end else if (cnt == LAST) begin
          duty_d = (ramp >= {1'b0, MAX_D}) ? MAX_D
                                           : ramp[CW-1:0];
        end
      end
      ST_DEAD: begin
        // a command flip-flopping back during DEAD
        // still waits out the full coast time
        if (cmd == DRV_STOP) begin
          state_d = ST_STOP;
        end else if (cmd == DRV_BRAKE) begin
          state_d = ST_BRAKE;
        end else if (dead_q == '0) begin
          state_d = (cmd == DRV_FWD) ? ST_FWD : ST_REV;
          duty_d  = MIN_D;
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end
      default: begin
        unique case (1'b1)
          cmd == DRV_FWD: begin
            state_d = ST_FWD;
            duty_d  = MIN_D;
          end
          cmd == DRV_REV: begin
            state_d = ST_REV;
            duty_d  = MIN_D;
          end
          cmd == DRV_BRAKE: begin
            state_d = ST_BRAKE;
            duty_d  = '0;
          end
          default: begin
            state_d = ST_STOP;
            duty_d  = '0;
          end
        endcase
      end
    endcase
  end

  // pins are registered against the counter value
  // that becomes visible on the same edge
  always_comb begin
    pins_d.en  = 1'b0;
    pins_d.inx = PINS_OFF;
    unique case (state_d)
      ST_FWD: begin
        pins_d.en  = (cnt_nxt < duty_d);
        pins_d.inx = PINS_FWD;
      end
      ST_REV: begin
        pins_d.en  = (cnt_nxt < duty_d);
        pins_d.inx = PINS_REV;
      end
      ST_BRAKE: begin
        pins_d.en  = 1'b1;
        pins_d.inx = PINS_BRK;
      end
      default: begin
        pins_d.en  = 1'b0;
        pins_d.inx = PINS_OFF;
      end
    endcase
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared period counter
// feeding two independent motor channels.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PERIOD    = 20,
  parameter int DUTY_MIN  = 5,
  parameter int DUTY_MAX  = 20,
  parameter int RAMP_STEP = 5,
  parameter int DEADTIME  = 10
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] DriveA,
  input  logic [1:0] DriveB,
  output logic       ENA,
  output logic       IN1,
  output logic       IN2,
  output logic       ENB,
  output logic       IN3,
  output logic       IN4
);

  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  bridge_t       pa, pb;

  assign cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0
                                            : cnt_q + CW'(1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  motor_channel #(
    .PERIOD   (PERIOD),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_cha (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .cmd    (DriveA),
    .cnt    (cnt_q),
    .cnt_nxt(cnt_d),
    .pins   (pa)
  );

  motor_channel #(
    .PERIOD   (PERIOD),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_chb (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .cmd    (DriveB),
    .cnt    (cnt_q),
    .cnt_nxt(cnt_d),
    .pins   (pb)
  );

  assign ENA        = pa.en;
  assign {IN1, IN2} = pa.inx;
  assign ENB        = pb.en;
  assign {IN3, IN4} = pb.inx;

endmodule
